// File: rtl/md5_sched_pkg.sv
// Shared types and constants for the MD5 job scheduler slice.
package md5_sched_pkg;

    localparam int IDX_W_DEF = 64;
    localparam int CHUNK_W   = 32;
    localparam int TEXT_W    = 128;

    typedef logic [CHUNK_W-1:0] chunk_len_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_DRAIN    = 2'd2,
        S_FOUND    = 2'd3
    } sched_state_e;

endpackage

// File: rtl/md5_job_scheduler_if.sv
// Job-control and core-fabric signals of the scheduler.
// master: host plus cracker cores; slave: the scheduler itself.
interface md5_job_scheduler_if
    import md5_sched_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = IDX_W_DEF
);
    // job control
    logic                        job_start;
    logic [IDX_W-1:0]            job_base;
    logic [IDX_W-1:0]            job_total;
    chunk_len_t                  chunk_len;
    logic                        job_abort;
    // core fabric
    logic [NUM_CORES-1:0]        core_idle;
    logic [NUM_CORES-1:0]        core_match;
    logic [NUM_CORES*TEXT_W-1:0] core_text;
    logic [NUM_CORES-1:0]        core_start;
    logic [IDX_W-1:0]            core_base;
    chunk_len_t                  core_len;
    logic                        core_stop;
    // status
    logic                        busy;
    logic                        found;
    logic [TEXT_W-1:0]           found_text;
    logic [3:0]                  found_core;
    logic                        job_done;
    logic [IDX_W-1:0]            issued;

    modport master (
        output job_start, job_base, job_total, chunk_len, job_abort,
        output core_idle, core_match, core_text,
        input  core_start, core_base, core_len, core_stop,
        input  busy, found, found_text, found_core, job_done, issued
    );

    modport slave (
        input  job_start, job_base, job_total, chunk_len, job_abort,
        input  core_idle, core_match, core_text,
        output core_start, core_base, core_len, core_stop,
        output busy, found, found_text, found_core, job_done, issued
    );

endinterface

// File: rtl/md5_rr_arbiter.sv
// Round-robin one-hot arbiter. Search starts at the core after the last
// granted one; the pointer only moves when the grant is actually used.
module md5_rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any
);

    logic [PW-1:0] ptr;
    int            k;

    // pick the first requester at or after the pointer, wrapping around
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        k         = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!any && req[k]) begin
                grant[k]  = 1'b1;
                grant_idx = PW'(k);
                any       = 1'b1;
            end
        end
    end

    // pointer moves past the core that was just served
    always_ff @(posedge clk) begin
        if (reset || clear)
            ptr <= '0;
        else if (advance && any)
            ptr <= (grant_idx == PW'(N-1)) ? '0 : grant_idx + PW'(1);
    end

endmodule

// File: rtl/md5_job_scheduler.sv
// Splits one MD5 brute-force job into chunks and hands them out to idle
// cracker cores round-robin; captures the first match and stops all cores.
module md5_job_scheduler
    import md5_sched_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = IDX_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    md5_job_scheduler_if.slave   bus
);

    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int LW = (IDX_W > CHUNK_W) ? IDX_W : CHUNK_W;

    sched_state_e         state, state_nxt;
    logic [IDX_W-1:0]     next_idx;
    logic [IDX_W-1:0]     remaining;
    chunk_len_t           chunk_q;
    logic [1:0]           drain_cnt;

    logic [NUM_CORES-1:0] arb_req, arb_grant;
    logic [PW-1:0]        arb_idx;
    logic                 arb_any;
    logic                 grant_en;
    logic                 last_chunk;
    logic                 drain_done;
    logic [LW-1:0]        eff_chunk, rem_w, gl;
    logic [PW-1:0]        midx;
    logic                 mhit;

    // a core started last cycle may still show idle, so mask it out
    assign arb_req = bus.core_idle & ~bus.core_start;

    md5_rr_arbiter #(.N(NUM_CORES)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == S_IDLE && bus.job_start),
        .req       (arb_req),
        .advance   (grant_en),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // chunk length for this grant: min(chunk_len, remaining), zero chunk means 1
    always_comb begin
        eff_chunk  = (chunk_q == '0) ? LW'(1) : LW'(chunk_q);
        rem_w      = LW'(remaining);
        gl         = (rem_w < eff_chunk) ? rem_w : eff_chunk;
        last_chunk = (rem_w == gl);
    end

    // lowest-index matching core wins
    always_comb begin
        midx = '0;
        mhit = 1'b0;
        for (int i = NUM_CORES-1; i >= 0; i--) begin
            if (bus.core_match[i]) begin
                midx = PW'(i);
                mhit = 1'b1;
            end
        end
    end

    // match and abort take priority over dispatching a new chunk
    assign grant_en   = (state == S_DISPATCH) && !mhit && !bus.job_abort && arb_any;
    // two cycles after the last launch every core has had time to drop idle
    assign drain_done = (state == S_DRAIN) && (drain_cnt == 2'd2) && (&bus.core_idle);
    assign bus.busy   = (state == S_DISPATCH) || (state == S_DRAIN);

    // state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:
                if (bus.job_start && bus.job_total != '0)
                    state_nxt = S_DISPATCH;
            S_DISPATCH:
                if (mhit)                      state_nxt = S_FOUND;
                else if (bus.job_abort)        state_nxt = S_IDLE;
                else if (grant_en && last_chunk) state_nxt = S_DRAIN;
            S_DRAIN:
                if (mhit)                      state_nxt = S_FOUND;
                else if (bus.job_abort)        state_nxt = S_IDLE;
                else if (drain_done)           state_nxt = S_IDLE;
            S_FOUND:
                state_nxt = S_IDLE;
            default:
                state_nxt = S_IDLE;
        endcase
    end

    // job bookkeeping, chunk launch and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.core_start <= '0;
            bus.core_base  <= '0;
            bus.core_len   <= '0;
            bus.core_stop  <= 1'b0;
            bus.found      <= 1'b0;
            bus.found_text <= '0;
            bus.found_core <= '0;
            bus.job_done   <= 1'b0;
            bus.issued     <= '0;
            next_idx       <= '0;
            remaining      <= '0;
            chunk_q        <= '0;
            drain_cnt      <= '0;
        end else begin
            bus.core_start <= '0;
            bus.core_stop  <= 1'b0;
            bus.job_done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.job_start) begin
                        next_idx       <= bus.job_base;
                        remaining      <= bus.job_total;
                        chunk_q        <= bus.chunk_len;
                        bus.issued     <= '0;
                        bus.found      <= 1'b0;
                        bus.found_text <= '0;
                        bus.found_core <= '0;
                        bus.job_done   <= (bus.job_total == '0);
                    end
                end
                S_DISPATCH, S_DRAIN: begin
                    if (mhit) begin
                        // stop/done/found are high during the FOUND cycle
                        bus.found      <= 1'b1;
                        bus.found_text <= bus.core_text[int'(midx)*TEXT_W +: TEXT_W];
                        bus.found_core <= 4'(midx);
                        bus.core_stop  <= 1'b1;
                        bus.job_done   <= 1'b1;
                    end else if (bus.job_abort) begin
                        bus.core_stop  <= 1'b1;
                        bus.job_done   <= 1'b1;
                    end else if (grant_en) begin
                        bus.core_start <= arb_grant;
                        bus.core_base  <= next_idx;
                        bus.core_len   <= CHUNK_W'(gl);
                        next_idx       <= next_idx + IDX_W'(gl);
                        remaining      <= remaining - IDX_W'(gl);
                        bus.issued     <= bus.issued + IDX_W'(gl);
                        drain_cnt      <= '0;
                    end else if (state == S_DRAIN) begin
                        if (drain_cnt != 2'd2)
                            drain_cnt <= drain_cnt + 2'd1;
                        if (drain_done)
                            bus.job_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md5_job_scheduler.sv
// Directed bench for md5_job_scheduler: expected launches and job-end
// results are queued by the stimulus and checked by a negedge monitor.
module tb_md5_job_scheduler;
    import md5_sched_pkg::*;

    localparam int NC = 4;
    localparam int IW = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    md5_job_scheduler_if #(.NUM_CORES(NC), .IDX_W(IW)) bus();

    md5_job_scheduler #(.NUM_CORES(NC), .IDX_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [NC-1:0] core;
        logic [IW-1:0] base;
        logic [31:0]   len;
    } start_t;

    typedef struct {
        logic          stop;
        logic          found;
        logic [3:0]    fcore;
        logic [127:0]  ftext;
        logic [IW-1:0] issued;
    } done_t;

    start_t sq[$];
    done_t  dq[$];
    int applied = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        applied++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_start(input logic [NC-1:0] c, input logic [IW-1:0] b, input logic [31:0] l);
        start_t s;
        s.core = c; s.base = b; s.len = l;
        sq.push_back(s);
    endtask

    task automatic push_done(input logic st, input logic f, input logic [3:0] fc,
                             input logic [127:0] ft, input logic [IW-1:0] iss);
        done_t d;
        d.stop = st; d.found = f; d.fcore = fc; d.ftext = ft; d.issued = iss;
        dq.push_back(d);
    endtask

    task automatic start_job(input logic [IW-1:0] b, input logic [IW-1:0] t, input logic [31:0] c);
        bus.job_base  = b;
        bus.job_total = t;
        bus.chunk_len = c;
        bus.job_start = 1'b1;
        tick();
        bus.job_start = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((bus.busy || dq.size() != 0) && n < lim) begin
            tick();
            n++;
        end
        if (n >= lim) begin
            applied++;
            errs++;
            $display("FAIL wait_idle: timed out after %0d cycles, busy=%0b pending=%0d", lim, bus.busy, dq.size());
        end
        tick();
    endtask

    // launch 2 chunks, then present match/abort vector in one cycle
    task automatic run_match(input logic [IW-1:0] b, input logic [NC-1:0] mv, input logic ab,
                             input logic f, input logic [3:0] fc, input logic [127:0] ft);
        push_start(4'b0001, b, 32'd4);
        push_start(4'b0010, b + 64'd4, 32'd4);
        push_done(1'b1, f, fc, ft, 64'd8);
        start_job(b, 64'd100, 32'd4);
        tick();
        tick();
        bus.core_match = mv;
        bus.job_abort  = ab;
        tick();
        bus.core_match = '0;
        bus.job_abort  = 1'b0;
        wait_idle(50);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        start_t s;
        done_t  d;
        if (!reset) begin
            if (bus.core_start != '0) begin
                if (sq.size() == 0) begin
                    chk("unexpected core_start", 128'(bus.core_start), 128'd0);
                end else begin
                    s = sq.pop_front();
                    chk("core_start", 128'(bus.core_start), 128'(s.core));
                    chk("core_base",  128'(bus.core_base),  128'(s.base));
                    chk("core_len",   128'(bus.core_len),   128'(s.len));
                end
            end
            if (bus.job_done) begin
                if (dq.size() == 0) begin
                    chk("unexpected job_done", 128'(bus.job_done), 128'd0);
                end else begin
                    d = dq.pop_front();
                    chk("core_stop@done", 128'(bus.core_stop),  128'(d.stop));
                    chk("found",          128'(bus.found),      128'(d.found));
                    chk("found_core",     128'(bus.found_core), 128'(d.fcore));
                    chk("found_text",     bus.found_text,       d.ftext);
                    chk("issued",         128'(bus.issued),     128'(d.issued));
                end
            end else if (bus.core_stop) begin
                chk("stray core_stop", 128'(bus.core_stop), 128'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.job_start  = 1'b0;
        bus.job_base   = '0;
        bus.job_total  = '0;
        bus.chunk_len  = '0;
        bus.job_abort  = 1'b0;
        bus.core_idle  = 4'b1111;
        bus.core_match = '0;
        bus.core_text  = '0;
        tick();
        tick();
        // reset state
        chk("rst core_start", 128'(bus.core_start), 128'd0);
        chk("rst busy",       128'(bus.busy),       128'd0);
        chk("rst found",      128'(bus.found),      128'd0);
        chk("rst job_done",   128'(bus.job_done),   128'd0);
        chk("rst issued",     128'(bus.issued),     128'd0);
        chk("rst core_base",  128'(bus.core_base),  128'd0);
        reset = 1'b0;
        tick();

        // basic split: 10 candidates in chunks of 4
        push_start(4'b0001, 64'h100, 32'd4);
        push_start(4'b0010, 64'h104, 32'd4);
        push_start(4'b0100, 64'h108, 32'd2);
        push_done(1'b0, 1'b0, 4'd0, 128'd0, 64'd10);
        start_job(64'h100, 64'd10, 32'd4);
        wait_idle(50);

        // only cores 1 and 3 idle; drain holds until all go idle
        push_start(4'b0010, 64'h0, 32'd4);
        push_start(4'b1000, 64'h4, 32'd4);
        push_start(4'b0010, 64'h8, 32'd4);
        push_done(1'b0, 1'b0, 4'd0, 128'd0, 64'd12);
        bus.core_idle = 4'b1010;
        start_job(64'h0, 64'd12, 32'd4);
        tick(); tick(); tick(); tick();
        chk("drain busy", 128'(bus.busy), 128'd1);
        bus.core_idle = 4'b1111;
        wait_idle(50);

        // chunk_len 0 acts as 1
        push_start(4'b0001, 64'h50, 32'd1);
        push_start(4'b0010, 64'h51, 32'd1);
        push_done(1'b0, 1'b0, 4'd0, 128'd0, 64'd2);
        start_job(64'h50, 64'd2, 32'd0);
        wait_idle(50);

        // match on core 2
        bus.core_text[2*128 +: 128] = 128'h6162;
        run_match(64'h1000, 4'b0100, 1'b0, 1'b1, 4'd2, 128'h6162);
        tick(); tick();
        chk("found held",      128'(bus.found),      128'd1);
        chk("found_text held", bus.found_text,       128'h6162);
        chk("found_core held", 128'(bus.found_core), 128'd2);

        // empty job: done one cycle after start, found cleared
        push_done(1'b0, 1'b0, 4'd0, 128'd0, 64'd0);
        start_job(64'h20, 64'd0, 32'd4);
        chk("empty job_done", 128'(bus.job_done), 128'd1);
        chk("found cleared",  128'(bus.found),    128'd0);
        wait_idle(50);

        // cores 1 and 3 match together: lowest wins
        bus.core_text[1*128 +: 128] = 128'h1111;
        bus.core_text[3*128 +: 128] = 128'h3333;
        run_match(64'h2000, 4'b1010, 1'b0, 1'b1, 4'd1, 128'h1111);

        // abort with match: match wins
        bus.core_text[0 +: 128] = 128'hA0A0;
        run_match(64'h3000, 4'b0001, 1'b1, 1'b1, 4'd0, 128'hA0A0);

        // abort alone
        run_match(64'h4000, 4'b0000, 1'b1, 1'b0, 4'd0, 128'd0);

        // index wraps past 2^64
        push_start(4'b0001, 64'hFFFF_FFFF_FFFF_FFFE, 32'd2);
        push_start(4'b0010, 64'h0, 32'd2);
        push_done(1'b0, 1'b0, 4'd0, 128'd0, 64'd4);
        start_job(64'hFFFF_FFFF_FFFF_FFFE, 64'd4, 32'd2);
        wait_idle(50);

        // reset mid-dispatch
        push_start(4'b0001, 64'h200, 32'd4);
        start_job(64'h200, 64'd100, 32'd4);
        chk("busy before reset", 128'(bus.busy), 128'd1);
        tick();
        @(negedge clk);
        #1;
        reset = 1'b1;
        tick();
        chk("mid rst core_start", 128'(bus.core_start), 128'd0);
        chk("mid rst core_base",  128'(bus.core_base),  128'd0);
        chk("mid rst core_len",   128'(bus.core_len),   128'd0);
        chk("mid rst core_stop",  128'(bus.core_stop),  128'd0);
        chk("mid rst busy",       128'(bus.busy),       128'd0);
        chk("mid rst job_done",   128'(bus.job_done),   128'd0);
        chk("mid rst issued",     128'(bus.issued),     128'd0);
        reset = 1'b0;
        tick();
        tick();

        chk("start queue drained", 128'(sq.size()), 128'd0);
        chk("done queue drained",  128'(dq.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
        $finish;
    end

endmodule
